// File: rtl/wb_shared_bus.sv
// Shared-bus Wishbone interconnect: round-robin arbitration among NM masters,
// address decode to NS slaves, bus-error generation on unmapped access or ack timeout.
module wb_shared_bus #(
   parameter int unsigned NM = 2,
   parameter int unsigned NS = 3,
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32,
   parameter logic [2*NS*AW-1:0] AddrRanges = {32'h0000_0000, 32'h0000_2FFC,
                                               32'h0000_3000, 32'h0000_3FFC,
                                               32'h0000_4000, 32'h0000_4000},
   parameter int unsigned TIMEOUT = 16,
   localparam int unsigned OW = (NM > 1) ? $clog2(NM) : 1
) (
   input  logic                 clk_in,
   input  logic                 reset_in,
   input  logic [NM-1:0]        m_cyc_in,
   input  logic [NM-1:0]        m_stb_in,
   input  logic [NM-1:0]        m_we_in,
   input  logic [NM*AW-1:0]     m_adr_in,
   input  logic [NM*DW-1:0]     m_dat_in,
   input  logic [NM*DW/8-1:0]   m_sel_in,
   output logic [DW-1:0]        m_dat_out,
   output logic [NM-1:0]        m_ack_out,
   output logic [NM-1:0]        m_err_out,
   output logic [NS-1:0]        s_cyc_out,
   output logic [NS-1:0]        s_stb_out,
   output logic                 s_we_out,
   output logic [AW-1:0]        s_adr_out,
   output logic [DW-1:0]        s_dat_out,
   output logic [DW/8-1:0]      s_sel_out,
   input  logic [NS*DW-1:0]     s_dat_in,
   input  logic [NS-1:0]        s_ack_in,
   output logic [OW-1:0]        owner_out,
   output logic                 busy_out
);

   localparam int unsigned SW = (NS > 1) ? $clog2(NS) : 1;
   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam int unsigned BW = DW / 8;

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ERR} state_e;

   state_e          state_q;
   logic [OW-1:0]   owner_q;
   logic [OW-1:0]   ptr_q;
   logic [CW-1:0]   tcnt_q;

   logic [AW-1:0]   own_adr;
   logic            own_cyc;
   logic            own_stb;
   logic            hit_vld;
   logic [SW-1:0]   hit_idx;
   logic            grant_vld;
   logic [OW-1:0]   grant_idx;
   logic [OW-1:0]   next_ptr;
   logic            slv_ack;
   logic            active;

   assign own_adr  = m_adr_in[int'(owner_q)*AW +: AW];
   assign own_cyc  = m_cyc_in[owner_q];
   assign own_stb  = m_stb_in[owner_q];
   assign next_ptr = OW'((int'(owner_q) + 1) % int'(NM));
   assign active   = (state_q == ST_BUSY) && !reset_in;

   // Address decode; scanning upward so the lowest-index slave wins on overlap.
   always_comb begin
      hit_vld = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < int'(NS); i++) begin
         if (!hit_vld &&
             own_adr >= AddrRanges[(2*(int'(NS)-1-i)+1)*AW +: AW] &&
             own_adr <= AddrRanges[(2*(int'(NS)-1-i))*AW +: AW]) begin
            hit_vld = 1'b1;
            hit_idx = SW'(i);
         end
      end
   end

   // Round-robin search starting at ptr_q.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < int'(NM); k++) begin
         if (!grant_vld && m_cyc_in[(int'(ptr_q) + k) % int'(NM)]) begin
            grant_vld = 1'b1;
            grant_idx = OW'((int'(ptr_q) + k) % int'(NM));
         end
      end
   end

   assign slv_ack = s_ack_in[hit_idx] & hit_vld & own_stb;

   always_comb begin
      s_cyc_out = '0;
      s_stb_out = '0;
      m_ack_out = '0;
      m_err_out = '0;
      m_dat_out = '0;
      if (active && hit_vld && own_cyc) begin
         s_cyc_out[hit_idx] = 1'b1;
         s_stb_out[hit_idx] = own_stb;
         m_ack_out[owner_q] = slv_ack;
         m_dat_out          = s_dat_in[int'(hit_idx)*DW +: DW];
      end
      if (state_q == ST_ERR && !reset_in) begin
         m_err_out[owner_q] = 1'b1;
      end
   end

   assign s_we_out  = m_we_in[owner_q];
   assign s_adr_out = own_adr;
   assign s_dat_out = m_dat_in[int'(owner_q)*DW +: DW];
   assign s_sel_out = m_sel_in[int'(owner_q)*BW +: BW];
   assign busy_out  = (state_q != ST_IDLE) && !reset_in;
   assign owner_out = reset_in ? '0 : owner_q;

   // Arbiter FSM with ack-timeout counter.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         tcnt_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               tcnt_q <= '0;
               if (grant_vld) begin
                  owner_q <= grant_idx;
                  state_q <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (!own_cyc) begin
                  state_q <= ST_IDLE;
                  ptr_q   <= next_ptr;
                  tcnt_q  <= '0;
               end else if (own_stb && !hit_vld) begin
                  state_q <= ST_ERR;
                  tcnt_q  <= '0;
               end else if (!own_stb || slv_ack) begin
                  tcnt_q  <= '0;
               end else if (tcnt_q == CW'(TIMEOUT - 1)) begin
                  state_q <= ST_ERR;
                  tcnt_q  <= '0;
               end else begin
                  tcnt_q  <= tcnt_q + CW'(1);
               end
            end
            ST_ERR: begin
               state_q <= ST_BUSY;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_shared_bus.sv
// Directed bench for wb_shared_bus with default parameters (2 masters, 3 slaves).
module tb_wb_shared_bus;

   logic          clk = 1'b0;
   logic          reset_in;
   logic [1:0]    m_cyc, m_stb, m_we;
   logic [63:0]   m_adr, m_dat;
   logic [7:0]    m_sel;
   logic [31:0]   m_dat_out;
   logic [1:0]    m_ack_out, m_err_out;
   logic [2:0]    s_cyc_out, s_stb_out;
   logic          s_we_out;
   logic [31:0]   s_adr_out, s_dat_out;
   logic [3:0]    s_sel_out;
   logic [95:0]   s_dat;
   logic [2:0]    s_ack;
   logic [0:0]    owner_out;
   logic          busy_out;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   wb_shared_bus dut (
      .clk_in    (clk),
      .reset_in  (reset_in),
      .m_cyc_in  (m_cyc),
      .m_stb_in  (m_stb),
      .m_we_in   (m_we),
      .m_adr_in  (m_adr),
      .m_dat_in  (m_dat),
      .m_sel_in  (m_sel),
      .m_dat_out (m_dat_out),
      .m_ack_out (m_ack_out),
      .m_err_out (m_err_out),
      .s_cyc_out (s_cyc_out),
      .s_stb_out (s_stb_out),
      .s_we_out  (s_we_out),
      .s_adr_out (s_adr_out),
      .s_dat_out (s_dat_out),
      .s_sel_out (s_sel_out),
      .s_dat_in  (s_dat),
      .s_ack_in  (s_ack),
      .owner_out (owner_out),
      .busy_out  (busy_out)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_in = 1'b1;
      m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '1;
      s_dat = '0; s_ack = '0;

      // Reset values
      tick(); tick(); #1;
      check("rst_busy",  64'(busy_out),  64'h0);
      check("rst_owner", 64'(owner_out), 64'h0);
      check("rst_scyc",  64'(s_cyc_out), 64'h0);
      check("rst_sstb",  64'(s_stb_out), 64'h0);
      check("rst_ack",   64'(m_ack_out), 64'h0);
      check("rst_err",   64'(m_err_out), 64'h0);
      check("rst_dat",   64'(m_dat_out), 64'h0);

      // M0 reads 0x3004, slave 1 acks after two wait cycles
      tick();
      reset_in = 1'b0;
      m_cyc = 2'b01; m_stb = 2'b01; m_adr[31:0] = 32'h3004;
      s_dat = {32'h2222_0000, 32'hCAFE_0001, 32'h1111_0000};
      #1;
      check("rd_idle_busy", 64'(busy_out), 64'h0);
      tick(); s_ack = 3'b001; #1;
      check("rd_w1_sstb",  64'(s_stb_out), 64'h2);
      check("rd_w1_scyc",  64'(s_cyc_out), 64'h2);
      check("rd_w1_ack_other_slave", 64'(m_ack_out), 64'h0);
      check("rd_w1_busy",  64'(busy_out), 64'h1);
      tick(); s_ack = 3'b000; #1;
      check("rd_w2_ack",   64'(m_ack_out), 64'h0);
      tick(); s_ack = 3'b010; #1;
      check("rd_ack_sstb", 64'(s_stb_out), 64'h2);
      check("rd_ack",      64'(m_ack_out), 64'h1);
      check("rd_ack_dat",  64'(m_dat_out), 64'hCAFE_0001);
      check("rd_ack_err",  64'(m_err_out), 64'h0);
      tick(); s_ack = '0; m_cyc = '0; m_stb = '0; #1;
      tick(); #1;
      check("rd_release_busy", 64'(busy_out), 64'h0);

      // Round-robin from a fresh reset
      tick(); reset_in = 1'b1; #1;
      tick(); reset_in = 1'b0; m_cyc = 2'b11; #1;
      check("rr_idle_busy", 64'(busy_out), 64'h0);
      tick(); m_cyc = 2'b10; #1;
      check("rr_first_owner", 64'(owner_out), 64'h0);
      check("rr_first_busy",  64'(busy_out),  64'h1);
      tick(); #1;
      check("rr_gap_busy", 64'(busy_out), 64'h0);
      tick(); m_cyc = 2'b00; #1;
      check("rr_second_owner", 64'(owner_out), 64'h1);
      check("rr_second_busy",  64'(busy_out),  64'h1);
      tick(); m_cyc = 2'b11; #1;
      check("rr_gap2_busy", 64'(busy_out), 64'h0);
      tick(); m_cyc = 2'b00; #1;
      check("rr_third_owner", 64'(owner_out), 64'h0);
      tick(); #1;

      // M1 writes unmapped 0x5000
      tick(); m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b10; m_adr[63:32] = 32'h5000; #1;
      tick(); #1;
      check("unm_owner", 64'(owner_out), 64'h1);
      check("unm_sstb",  64'(s_stb_out), 64'h0);
      check("unm_scyc",  64'(s_cyc_out), 64'h0);
      check("unm_err_pre", 64'(m_err_out), 64'h0);
      tick(); m_stb = 2'b00; #1;
      check("unm_err",  64'(m_err_out), 64'h2);
      check("unm_err_sstb", 64'(s_stb_out), 64'h0);
      check("unm_err_ack",  64'(m_ack_out), 64'h0);
      tick(); m_cyc = 2'b00; #1;
      check("unm_err_post", 64'(m_err_out), 64'h0);

      // M0 strobes 0x0000, slave 0 never acks
      tick(); m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b00; m_adr[31:0] = 32'h0; #1;
      for (int i = 0; i < 16; i++) begin
         tick(); #1;
         check("to_wait_sstb", 64'(s_stb_out), 64'h1);
         check("to_wait_err",  64'(m_err_out), 64'h0);
      end
      tick(); m_stb = 2'b00; #1;
      check("to_err",      64'(m_err_out), 64'h1);
      check("to_err_sstb", 64'(s_stb_out), 64'h0);
      check("to_err_scyc", 64'(s_cyc_out), 64'h0);
      tick(); m_cyc = 2'b00; #1;
      check("to_err_post", 64'(m_err_out), 64'h0);

      // M0 four-beat block to slave 1 while M1 requests slave 0
      tick(); m_cyc = 2'b01; m_stb = 2'b01; m_adr[31:0] = 32'h3000;
      s_ack = 3'b010; s_dat[63:32] = 32'hB0; #1;
      check("blk_idle_ack", 64'(m_ack_out), 64'h0);
      for (int b = 0; b < 4; b++) begin
         tick();
         m_adr[31:0] = 32'h3000 + 32'(4*b);
         s_dat[63:32] = 32'hB0 + 32'(b);
         m_cyc = 2'b11; m_stb = 2'b11; m_adr[63:32] = 32'h0;
         #1;
         check("blk_ack",   64'(m_ack_out), 64'h1);
         check("blk_owner", 64'(owner_out), 64'h0);
         check("blk_dat",   64'(m_dat_out), 64'hB0 + 64'(b));
      end
      tick(); m_cyc = 2'b10; m_stb = 2'b10; s_ack = '0; #1;
      check("blk_drop_ack", 64'(m_ack_out), 64'h0);
      tick(); #1;
      check("blk_gap_busy", 64'(busy_out), 64'h0);
      tick(); #1;
      check("blk_m1_owner", 64'(owner_out), 64'h1);
      check("blk_m1_sstb",  64'(s_stb_out), 64'h1);
      check("blk_m1_ack",   64'(m_ack_out), 64'h0);

      // Reset during M1's pending strobe
      tick(); reset_in = 1'b1; #1;
      check("abort_sstb", 64'(s_stb_out), 64'h0);
      check("abort_scyc", 64'(s_cyc_out), 64'h0);
      check("abort_busy", 64'(busy_out),  64'h0);
      tick(); #1;
      check("post_rst_busy",  64'(busy_out),  64'h0);
      check("post_rst_owner", 64'(owner_out), 64'h0);
      check("post_rst_sstb",  64'(s_stb_out), 64'h0);
      check("post_rst_scyc",  64'(s_cyc_out), 64'h0);
      check("post_rst_ack",   64'(m_ack_out), 64'h0);
      check("post_rst_err",   64'(m_err_out), 64'h0);
      check("post_rst_dat",   64'(m_dat_out), 64'h0);

      m_cyc = '0; m_stb = '0;
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
